tblink_rpc_call_mux: RTL and testbench
======================================

# tblink_rpc_call_mux

Multi-channel hardware call multiplexer for TBLink RPC BFMs: accepts method invocations from NUM_CHANNELS HDL-side requesters, tags each with a unique call_id from a bounded pool, serialises them onto one outbound invoke stream, and routes returning responses by call_id back to the originating channel. It sits between per-interface BFM logic and the single DPI/transport-facing message port. It generalises one-call-at-a-time invocation to parametrised channel count and parametrised outstanding depth, with out-of-order response matching and optional per-call timeout.

## Interface
- NUM_CHANNELS, 4, requester channels (≥1)
- MAX_OUTSTANDING, 8, call-table entries; power of two; ID_W = $clog2(MAX_OUTSTANDING), min 1
- METHOD_W, 8, method-id width
- PARAM_W, 64, packed parameter width
- RET_W, 64, return-value width
- TIMEOUT_CYCLES, 1024, cycles before an outstanding call expires (used only with timeout compiled in)

- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid / req_ready  in / out  NUM_CHANNELS  per-channel request handshake
- req_method  in  NUM_CHANNELS*METHOD_W  channel c at [c*METHOD_W +: METHOD_W]
- req_params  in  NUM_CHANNELS*PARAM_W  packed params per channel
- out_valid / out_ready  out / in  1  outbound invoke handshake
- out_call_id  out  ID_W  allocated tag
- out_method / out_params  out  METHOD_W / PARAM_W  forwarded request
- in_valid / in_ready  in / out  1  inbound response handshake
- in_call_id / in_retval  in  ID_W / RET_W  response tag and value
- rsp_valid / rsp_ready  out / in  NUM_CHANNELS  per-channel response handshake
- rsp_call_id  out  NUM_CHANNELS*ID_W  tag of delivered response
- rsp_retval  out  NUM_CHANNELS*RET_W  return value
- rsp_error  out  NUM_CHANNELS  1 = timed-out call (retval 0)
- outstanding  out  ID_W+1  valid call-table entries
- stray_err  out  1  sticky: response with unknown call_id

## Operation
- Call table: per entry valid bit + owning channel index (+ timer if enabled).
- Issue: output register holds one request. Loads when empty or consumed this cycle (out_valid && out_ready), at least one free entry exists, and a channel is granted. Grant is round-robin among req_valid, starting from channel after last grant. req_ready[c] = 1 only for granted channel on load cycle. Allocated ID = lowest-index free entry (from registered table state); entry marked valid, owner = c.
- Outbound holds stable while out_valid && !out_ready.
- Response: in_ready = 1 when in_call_id is a valid entry and its owner's response register is empty or draining this cycle; also 1 when in_call_id is invalid (stray). Combinational path in_call_id -> in_ready is intentional.
- Accepted valid response: loaded to owner's response register (rsp_error=0), entry freed at same edge.
- Stray: dropped, stray_err set; cleared only by reset.
- Per-channel response register: one entry; holds until rsp_ready.

## Timing
- Reset: out_valid, req_ready, rsp_valid, rsp_error, stray_err = 0; outstanding = 0; table cleared; RR pointer = channel 0. Reset mid-operation discards all calls; later responses count as stray.
- Request accepted edge N -> out_valid at N+1. Response accepted edge M -> rsp_valid at M+1.
- Freed ID reusable from edge M+1.
- Table full: no load; req_ready all 0 until a free occurs.
- Simultaneous alloc and free in one cycle: both applied; outstanding unchanged.

## Configuration
- TBLINK_RPC_CALL_TIMEOUT_EN defined: per-entry counter starts at 0 on allocation, increments each cycle while valid. At TIMEOUT_CYCLES entry is expired. When owner's response register is free and no inbound response targets that channel this cycle (inbound wins), lowest-index expired entry for the channel loads rsp_error=1, retval=0, its call_id; entry freed. A response arriving for an expired but not yet delivered entry is handled normally. Late responses after delivery are stray.
- Not defined: no counters, rsp_error tied 0, TIMEOUT_CYCLES ignored.

## Structure
- Shared package tblink_rpc_hdl_pkg: call-table entry struct, ID_W helper function.
- One sub-module: tblink_rpc_rr_arb (parametrised round-robin arbiter, req/grant vectors, pointer advance on accept).

## Test plan
- NUM_CHANNELS=4, MAX_OUTSTANDING=8 defaults unless noted.
- Single call ch2 method 0x11 params 0xA5 -> out_call_id 0, next cycle; in_call_id 0 retval 0x5A -> ch2 rsp_valid next cycle, retval 0x5A, outstanding 1->0.
- All 4 channels valid continuously, out_ready=1 -> grants 0,1,2,3,0… IDs 0..7 then req_ready stays 0 until any response frees an ID.
- Responses returned order 5,2,7 -> each routed to correct owner with matching rsp_call_id; freed ID 2 is next allocated.
- in_call_id=3 with no call outstanding -> in_ready=1, no rsp_valid, stray_err=1 and stays 1.
- Owner rsp_ready=0 with pending response, second response for same channel -> in_ready=0 until drained; reset_n pulse mid-stream -> all outputs 0, outstanding 0.
- Macro defined, TIMEOUT_CYCLES=16, no response -> rsp_error=1 retval 0 at cycle 17 after allocation; later response for that ID -> stray_err=1.

Source files
------------

// File: rtl/tblink_rpc_hdl_pkg.sv
// Shared types and helpers for the TBLink RPC HDL-side call multiplexer.
package tblink_rpc_hdl_pkg;

  // Owner field is wide enough for up to 256 requester channels.
  localparam int OWNER_W = 8;

  // One call-table entry: in-flight flag plus the channel that issued the call.
  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } call_entry_t;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tblink_rpc_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around; the pointer moves past the winner when the grant is used.
module tblink_rpc_rr_arb
  import tblink_rpc_hdl_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_accept,
  output logic             o_any,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_hi_any;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Winner search: lowest requester at/above the pointer, else lowest overall.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    o_any    = 1'b0;
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any    = 1'b1;
        w_lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= r_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = IDX_W'(i);
        end
      end
    end
    o_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    o_grant     = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = o_any && (o_grant_idx == IDX_W'(i));
    end
  end

  // Pointer advances to the channel after the winner only when the grant is taken.
  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_accept && o_any) begin
      r_ptr <= (o_grant_idx == IDX_W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tblink_rpc_call_mux.sv
// Multi-channel call multiplexer: tags requests with a call_id from a bounded
// table, serialises them onto one invoke stream and routes responses back to
// the issuing channel by call_id.
// Optional per-call timeout: define TBLINK_RPC_CALL_TIMEOUT_EN.
module tblink_rpc_call_mux
  import tblink_rpc_hdl_pkg::*;
#(
  parameter  int NUM_CHANNELS    = 4,
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int METHOD_W        = 8,
  parameter  int PARAM_W         = 64,
  parameter  int RET_W           = 64,
  parameter  int TIMEOUT_CYCLES  = 1024,
  localparam int ID_W            = clog2_min1(MAX_OUTSTANDING)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CHANNELS-1:0]      i_req_valid,
  output logic [NUM_CHANNELS-1:0]      o_req_ready,
  input  logic [NUM_CHANNELS*METHOD_W-1:0] i_req_method,
  input  logic [NUM_CHANNELS*PARAM_W-1:0]  i_req_params,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [ID_W-1:0]              o_out_call_id,
  output logic [METHOD_W-1:0]          o_out_method,
  output logic [PARAM_W-1:0]           o_out_params,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [ID_W-1:0]              i_in_call_id,
  input  logic [RET_W-1:0]             i_in_retval,
  output logic [NUM_CHANNELS-1:0]      o_rsp_valid,
  input  logic [NUM_CHANNELS-1:0]      i_rsp_ready,
  output logic [NUM_CHANNELS*ID_W-1:0] o_rsp_call_id,
  output logic [NUM_CHANNELS*RET_W-1:0] o_rsp_retval,
  output logic [NUM_CHANNELS-1:0]      o_rsp_error,
  output logic [ID_W:0]                o_outstanding,
  output logic                         o_stray_err
);

  localparam int CH_W = clog2_min1(NUM_CHANNELS);

  call_entry_t                 r_table [MAX_OUTSTANDING];
  logic                        r_out_valid;
  logic [ID_W-1:0]             r_out_call_id;
  logic [METHOD_W-1:0]         r_out_method;
  logic [PARAM_W-1:0]          r_out_params;
  logic [NUM_CHANNELS-1:0]     r_rsp_valid;
  logic [ID_W-1:0]             r_rsp_call_id [NUM_CHANNELS];
  logic [RET_W-1:0]            r_rsp_retval  [NUM_CHANNELS];
  logic                        r_stray_err;

  logic                        w_free_any;
  logic [ID_W-1:0]             w_free_id;
  logic [ID_W:0]               w_count;
  logic                        w_load_ok;
  logic                        w_load;
  logic                        w_arb_any;
  logic [NUM_CHANNELS-1:0]     w_grant;
  logic [CH_W-1:0]             w_grant_idx;
  call_entry_t                 w_in_entry;
  logic                        w_in_hit;
  logic [NUM_CHANNELS-1:0]     w_in_tgt;
  logic [NUM_CHANNELS-1:0]     w_rsp_free;
  logic                        w_in_acc;
  logic                        w_in_deliver;
  logic [MAX_OUTSTANDING-1:0]  w_to_free;
  logic [MAX_OUTSTANDING-1:0]  w_free_mask;

  // Lowest free entry and occupancy, both from registered table state.
  always_comb begin
    w_free_any = 1'b0;
    w_free_id  = '0;
    w_count    = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_table[i].valid) begin
        w_free_any = 1'b1;
        w_free_id  = ID_W'(i);
      end
      w_count = w_count + {{ID_W{1'b0}}, r_table[i].valid};
    end
  end

  assign w_load_ok = (!r_out_valid || i_out_ready) && w_free_any;
  assign w_load    = w_load_ok && w_arb_any;

  tblink_rpc_rr_arb #(.N(NUM_CHANNELS)) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req_valid),
    .i_accept    (w_load_ok),
    .o_any       (w_arb_any),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign o_req_ready = w_load ? w_grant : '0;

  // Outbound register: reload when empty or being consumed, otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_call_id <= '0;
      r_out_method  <= '0;
      r_out_params  <= '0;
    end else if (w_load) begin
      r_out_valid   <= 1'b1;
      r_out_call_id <= w_free_id;
      r_out_method  <= i_req_method[w_grant_idx*METHOD_W +: METHOD_W];
      r_out_params  <= i_req_params[w_grant_idx*PARAM_W +: PARAM_W];
    end else if (i_out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  // Inbound lookup: a known id routes to its owner; an unknown id is a stray
  // that is always accepted so it can never stall the transport.
  always_comb begin
    w_in_entry = r_table[i_in_call_id];
    w_in_hit   = w_in_entry.valid;
    w_rsp_free = '0;
    w_in_tgt   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_rsp_free[c] = !r_rsp_valid[c] || i_rsp_ready[c];
      w_in_tgt[c]   = w_in_hit && (w_in_entry.owner == OWNER_W'(c));
    end
  end

  assign o_in_ready   = !w_in_hit || |(w_in_tgt & w_rsp_free);
  assign w_in_acc     = i_in_valid && o_in_ready;
  assign w_in_deliver = w_in_acc && w_in_hit;

`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0]        r_timer [MAX_OUTSTANDING];
  logic [NUM_CHANNELS-1:0] r_rsp_error;
  logic [NUM_CHANNELS-1:0] w_to_fire;
  logic [ID_W-1:0]         w_to_id [NUM_CHANNELS];

  // Per channel, pick the lowest expired entry; an inbound response to that
  // channel in the same cycle takes priority.
  always_comb begin
    w_to_fire = '0;
    w_to_free = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_to_id[c] = '0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
        if (r_table[i].valid && (r_table[i].owner == OWNER_W'(c)) &&
            (r_timer[i] == TMR_W'(TIMEOUT_CYCLES))) begin
          w_to_fire[c] = 1'b1;
          w_to_id[c]   = ID_W'(i);
        end
      end
      w_to_fire[c] = w_to_fire[c] && w_rsp_free[c] && !(w_in_acc && w_in_tgt[c]);
      if (w_to_fire[c]) w_to_free[w_to_id[c]] = 1'b1;
    end
  end

  // Age counters: restart on allocation, saturate at the expiry value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_timer[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_load && (w_free_id == ID_W'(i))) begin
          r_timer[i] <= '0;
        end else if (r_table[i].valid && (r_timer[i] != TMR_W'(TIMEOUT_CYCLES))) begin
          r_timer[i] <= r_timer[i] + 1'b1;
        end
      end
    end
  end

  assign o_rsp_error = r_rsp_error;
`else
  assign w_to_free   = '0;
  assign o_rsp_error = '0;
`endif

  // An entry is released by a delivered response or by its timeout firing.
  always_comb begin
    w_free_mask = w_to_free;
    if (w_in_deliver) w_free_mask[i_in_call_id] = 1'b1;
  end

  // Call table: allocation and release never target the same entry in one cycle.
  // NOTE: the table is reset explicitly; its valid bits are control state, not payload storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_table[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_load && (w_free_id == ID_W'(i))) begin
          r_table[i].valid <= 1'b1;
          r_table[i].owner <= OWNER_W'(w_grant_idx);
        end else if (w_free_mask[i]) begin
          r_table[i].valid <= 1'b0;
        end
      end
    end
  end

  // Per-channel response registers: one slot each, held until the channel takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_rsp_call_id[c] <= '0;
        r_rsp_retval[c]  <= '0;
      end
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
      r_rsp_error <= '0;
`endif
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_in_deliver && w_in_tgt[c]) begin
          r_rsp_valid[c]   <= 1'b1;
          r_rsp_call_id[c] <= i_in_call_id;
          r_rsp_retval[c]  <= i_in_retval;
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
          r_rsp_error[c]   <= 1'b0;
        end else if (w_to_fire[c]) begin
          r_rsp_valid[c]   <= 1'b1;
          r_rsp_call_id[c] <= w_to_id[c];
          r_rsp_retval[c]  <= '0;
          r_rsp_error[c]   <= 1'b1;
`endif
        end else if (i_rsp_ready[c]) begin
          r_rsp_valid[c]   <= 1'b0;
        end
      end
    end
  end

  // Sticky flag for responses carrying an id that is not in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stray_err <= 1'b0;
    end else if (w_in_acc && !w_in_hit) begin
      r_stray_err <= 1'b1;
    end
  end

  // Flatten per-channel response registers onto the packed output buses.
  always_comb begin
    o_rsp_call_id = '0;
    o_rsp_retval  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      o_rsp_call_id[c*ID_W +: ID_W]   = r_rsp_call_id[c];
      o_rsp_retval[c*RET_W +: RET_W]  = r_rsp_retval[c];
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_call_id = r_out_call_id;
  assign o_out_method  = r_out_method;
  assign o_out_params  = r_out_params;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_outstanding = w_count;
  assign o_stray_err   = r_stray_err;

endmodule

// File: tb/tb_tblink_rpc_call_mux.sv
// Self-checking bench for tblink_rpc_call_mux (4 channels, 8 call ids).
module tb_tblink_rpc_call_mux;

  localparam int NC = 4;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NC-1:0]  req_valid = '0;
  logic [NC-1:0]  req_ready;
  logic [NC*8-1:0]  req_method;
  logic [NC*64-1:0] req_params;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [IW-1:0]  out_call_id;
  logic [7:0]     out_method;
  logic [63:0]    out_params;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [IW-1:0]  in_call_id = '0;
  logic [63:0]    in_retval = '0;
  logic [NC-1:0]  rsp_valid;
  logic [NC-1:0]  rsp_ready = '0;
  logic [NC*IW-1:0] rsp_call_id;
  logic [NC*64-1:0] rsp_retval;
  logic [NC-1:0]  rsp_error;
  logic [IW:0]    outstanding;
  logic           stray_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Fixed per-channel request payloads.
  assign req_method = {8'h23, 8'h11, 8'h21, 8'h20};
  assign req_params = {64'hB3, 64'hA5, 64'hB1, 64'hB0};

  tblink_rpc_call_mux #(
    .NUM_CHANNELS(NC), .MAX_OUTSTANDING(8), .METHOD_W(8),
    .PARAM_W(64), .RET_W(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_method(req_method), .i_req_params(req_params),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_call_id(out_call_id), .o_out_method(out_method), .o_out_params(out_params),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_call_id(in_call_id), .i_in_retval(in_retval),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_call_id(rsp_call_id), .o_rsp_retval(rsp_retval),
    .o_rsp_error(rsp_error), .o_outstanding(outstanding), .o_stray_err(stray_err)
  );

  typedef struct {
    string       name;
    logic [3:0]  rv;
    logic        ordy;
    logic        iv;
    logic [2:0]  iid;
    logic [63:0] iret;
    logic [3:0]  rr;
    logic [3:0]  e_rq;
    logic        e_ov;
    logic [2:0]  e_oid;
    logic [7:0]  e_om;
    logic [63:0] e_op;
    logic        e_ir;
    logic [3:0]  e_rspv;
    logic [3:0]  e_outst;
    logic        e_stray;
    int          rch;
    logic [2:0]  e_rid;
    logic [63:0] e_rret;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; in_valid = 1'b0;
    in_call_id = '0; in_retval = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  function automatic void add(input string n, input logic [3:0] rv, input logic ordy,
      input logic iv, input logic [2:0] iid, input logic [63:0] iret, input logic [3:0] rr,
      input logic [3:0] e_rq, input logic e_ov, input logic [2:0] e_oid, input logic [7:0] e_om,
      input logic [63:0] e_op, input logic e_ir, input logic [3:0] e_rspv, input logic [3:0] e_outst,
      input logic e_stray, input int rch, input logic [2:0] e_rid, input logic [63:0] e_rret);
    vec_t v;
    v.name = n; v.rv = rv; v.ordy = ordy; v.iv = iv; v.iid = iid; v.iret = iret; v.rr = rr;
    v.e_rq = e_rq; v.e_ov = e_ov; v.e_oid = e_oid; v.e_om = e_om; v.e_op = e_op; v.e_ir = e_ir;
    v.e_rspv = e_rspv; v.e_outst = e_outst; v.e_stray = e_stray;
    v.rch = rch; v.e_rid = e_rid; v.e_rret = e_rret;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [89:0] act, exp;
    int ids[3];
    int owns[3];
    logic [63:0] rets[3];

    //   name            rv ordy iv iid ret   rr  | rq ov oid om     op     ir rspv out st | rch rid ret
    add("idle_reset",    4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 0, -1, 0, 0);
    add("ch2_request",   4'h4, 1, 0, 0, 0,     4'hF, 4'h4, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 0, -1, 0, 0);
    add("ch2_issued",    4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 1, 0, 8'h11, 64'hA5, 1, 4'h0, 1, 0, -1, 0, 0);
    add("rsp_id0",       4'h0, 1, 1, 0, 64'h5A,4'h0, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 1, 0, -1, 0, 0);
    add("rsp_hold",      4'h0, 1, 0, 0, 0,     4'h0, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h4, 0, 0,  2, 0, 64'h5A);
    add("rsp_drain",     4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h4, 0, 0,  2, 0, 64'h5A);
    add("idle_drained",  4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 0, -1, 0, 0);
    add("stray_in",      4'h0, 1, 1, 3, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 0, -1, 0, 0);
    add("stray_set",     4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 1, -1, 0, 0);
    add("stray_sticky",  4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 1, -1, 0, 0);
    add("ch0_request",   4'h1, 1, 0, 0, 0,     4'hF, 4'h1, 0, 0, 8'h00, 64'h00, 1, 4'h0, 0, 1, -1, 0, 0);
    add("alloc_and_free",4'h2, 1, 1, 0, 64'h77,4'hF, 4'h2, 1, 0, 8'h20, 64'hB0, 1, 4'h0, 1, 1, -1, 0, 0);
    add("both_applied",  4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 1, 1, 8'h21, 64'hB1, 1, 4'h1, 1, 1,  0, 0, 64'h77);
    add("idle_after",    4'h0, 1, 0, 0, 0,     4'hF, 4'h0, 0, 0, 8'h00, 64'h00, 1, 4'h0, 1, 1, -1, 0, 0);

    do_reset();
    check("reset_rsp_error", rsp_error, 4'h0);

    // Table-driven single call, stray and simultaneous alloc/free.
    foreach (vecs[k]) begin
      req_valid = vecs[k].rv; out_ready = vecs[k].ordy; in_valid = vecs[k].iv;
      in_call_id = vecs[k].iid; in_retval = vecs[k].iret; rsp_ready = vecs[k].rr;
      #1;
      act = {req_ready, out_valid, out_valid ? out_call_id : 3'd0, out_valid ? out_method : 8'd0,
             out_valid ? out_params : 64'd0, in_ready, rsp_valid, outstanding, stray_err};
      exp = {vecs[k].e_rq, vecs[k].e_ov, vecs[k].e_oid, vecs[k].e_om, vecs[k].e_op,
             vecs[k].e_ir, vecs[k].e_rspv, vecs[k].e_outst, vecs[k].e_stray};
      check(vecs[k].name, act, exp);
      if (vecs[k].rch >= 0)
        check({vecs[k].name, "_rsp"}, {rsp_call_id[vecs[k].rch*IW +: IW], rsp_retval[vecs[k].rch*64 +: 64]},
              {vecs[k].e_rid, vecs[k].e_rret});
      cyc();
    end

    // Fill the table from all four channels: round-robin grants, ids 0..7.
    do_reset();
    rsp_ready = 4'hF; out_ready = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fill_grant%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k > 0) check($sformatf("fill_id%0d", k - 1), {out_valid, out_call_id}, {1'b1, 3'(k - 1)});
      cyc();
    end
    check("full_req_ready", req_ready, 4'h0);
    check("full_last_id", {out_valid, out_call_id}, {1'b1, 3'd7});
    check("full_outstanding", outstanding, 4'd8);
    cyc();
    check("full_still_blocked", {req_ready, out_valid}, 5'h0);

    // Out-of-order responses 5, 2, 7 (owners 1, 2, 3).
    req_valid = '0;
    ids = '{5, 2, 7}; owns = '{1, 2, 3}; rets = '{64'h55, 64'h22, 64'h77};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_call_id = 3'(ids[i]); in_retval = rets[i];
      #1;
      check($sformatf("ooo_in_ready%0d", ids[i]), in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      #1;
      check($sformatf("ooo_route%0d", ids[i]), rsp_valid, 4'b0001 << owns[i]);
      check($sformatf("ooo_payload%0d", ids[i]),
            {rsp_call_id[owns[i]*IW +: IW], rsp_retval[owns[i]*64 +: 64]}, {3'(ids[i]), rets[i]});
      check($sformatf("ooo_outstanding%0d", ids[i]), outstanding, 4'(7 - i));
      cyc();
    end
    req_valid = 4'b0001;
    #1;
    check("reuse_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    #1;
    check("reuse_lowest_id2", {out_valid, out_call_id, out_method}, {1'b1, 3'd2, 8'h20});
    cyc();

    // Back-pressure on channel 0 (owns ids 0, 2, 4).
    rsp_ready = 4'b1110;
    in_valid = 1'b1; in_call_id = 3'd0; in_retval = 64'hA0;
    #1;
    check("bp_first_accept", in_ready, 1'b1);
    cyc();
    in_call_id = 3'd4; in_retval = 64'hA4;
    #1;
    check("bp_first_held", {rsp_valid[0], rsp_call_id[IW-1:0]}, {1'b1, 3'd0});
    check("bp_blocked", in_ready, 1'b0);
    cyc();
    check("bp_still_blocked", {in_ready, rsp_retval[63:0]}, {1'b0, 64'hA0});
    rsp_ready = 4'hF;
    #1;
    check("bp_drain_accept", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("bp_second_payload", {rsp_valid[0], rsp_call_id[IW-1:0], rsp_retval[63:0]}, {1'b1, 3'd4, 64'hA4});
    check("bp_outstanding", outstanding, 4'd4);
    cyc();

    // Reset pulse mid-stream with a pending invoke and a pending response.
    req_valid = 4'hF; out_ready = 1'b0; rsp_ready = 4'h0;
    in_valid = 1'b1; in_call_id = 3'd1; in_retval = 64'h11;
    #1;
    cyc();
    in_valid = 1'b0;
    #1;
    check("pre_reset_busy", {out_valid, out_call_id, rsp_valid, req_ready}, {1'b1, 3'd0, 4'b0010, 4'h0});
    cyc();
    check("out_hold_stable", {out_valid, out_call_id, out_method}, {1'b1, 3'd0, 8'h21});
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("mid_reset_zero", {out_valid, req_ready, rsp_valid, rsp_error, stray_err, outstanding},
          {1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 4'hF;
    in_valid = 1'b1; in_call_id = 3'd1; in_retval = 64'h11;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("post_reset_stray", {stray_err, rsp_valid}, {1'b1, 4'h0});

`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
    // Timeout: channel 1 call never answered, expires 17 cycles after allocation.
    do_reset();
    out_ready = 1'b1; rsp_ready = 4'h0; req_valid = 4'b0010;
    #1;
    check("to_alloc", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    for (int k = 1; k <= 16; k++) cyc();
    check("to_not_yet", {rsp_valid, outstanding}, {4'h0, 4'd1});
    cyc();
    check("to_fired", {rsp_valid, rsp_error, rsp_call_id[IW +: IW], rsp_retval[64 +: 64], outstanding},
          {4'b0010, 4'b0010, 3'd0, 64'd0, 4'd0});
    rsp_ready = 4'hF;
    in_valid = 1'b1; in_call_id = 3'd0; in_retval = 64'h99;
    #1;
    cyc();
    in_valid = 1'b0;
    #1;
    check("to_late_stray", {stray_err, rsp_valid}, {1'b1, 4'h0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
